// File: rtl/note_detector.sv
// Square-wave tone decoder: measures the i_Note period, folds it into octave 4 and matches a semitone.
// Optional NOTE_DEBOUNCE_EN: publish a note only after two identical consecutive decodes.
module note_detector #(
  parameter int CLK_FREQ       = 50000000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_Note,
  output logic [8:0] o_NoteCode,
  output logic       o_Valid,
  output logic       o_Busy,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEASURE   = 3'd1,
    NORMALIZE = 3'd2,
    MATCH     = 3'd3,
    EMIT      = 3'd4
  } state_t;

  localparam logic [8:0] REST = 9'h111;
  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_L    = 2'd1;
  localparam logic [1:0] DIR_R    = 2'd2;

  // Octave-4 semitone periods in clock cycles, plus the neighbours that close the outer windows.
  localparam int P_B3  = $rtoi(CLK_FREQ / 246.94);
  localparam int P_C4  = $rtoi(CLK_FREQ / 261.63);
  localparam int P_CS4 = $rtoi(CLK_FREQ / 277.18);
  localparam int P_D4  = $rtoi(CLK_FREQ / 293.66);
  localparam int P_DS4 = $rtoi(CLK_FREQ / 311.13);
  localparam int P_E4  = $rtoi(CLK_FREQ / 329.63);
  localparam int P_F4  = $rtoi(CLK_FREQ / 349.23);
  localparam int P_FS4 = $rtoi(CLK_FREQ / 369.99);
  localparam int P_G4  = $rtoi(CLK_FREQ / 392.00);
  localparam int P_GS4 = $rtoi(CLK_FREQ / 415.30);
  localparam int P_A4  = $rtoi(CLK_FREQ / 440.00);
  localparam int P_AS4 = $rtoi(CLK_FREQ / 466.16);
  localparam int P_B4  = $rtoi(CLK_FREQ / 493.88);
  localparam int P_C5  = $rtoi(CLK_FREQ / 523.25);

  localparam logic [31:0] WIN_LO = 32'((P_B4 + P_C5) / 2);
  localparam logic [31:0] WIN_HI = 32'((P_B3 + P_C4) / 2);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  // Lower edge of each semitone window; periods shrink as the index rises.
  function automatic logic [31:0] lower_bound(input logic [3:0] i);
    case (i)
      4'd0:    return 32'((P_C4  + P_CS4) / 2);
      4'd1:    return 32'((P_CS4 + P_D4)  / 2);
      4'd2:    return 32'((P_D4  + P_DS4) / 2);
      4'd3:    return 32'((P_DS4 + P_E4)  / 2);
      4'd4:    return 32'((P_E4  + P_F4)  / 2);
      4'd5:    return 32'((P_F4  + P_FS4) / 2);
      4'd6:    return 32'((P_FS4 + P_G4)  / 2);
      4'd7:    return 32'((P_G4  + P_GS4) / 2);
      4'd8:    return 32'((P_GS4 + P_A4)  / 2);
      4'd9:    return 32'((P_A4  + P_AS4) / 2);
      4'd10:   return 32'((P_AS4 + P_B4)  / 2);
      default: return WIN_LO;
    endcase
  endfunction

  function automatic logic [4:0] semi_code(input logic [3:0] i);
    case (i)
      4'd0:    return 5'h0C;
      4'd1:    return 5'h1C;
      4'd2:    return 5'h0D;
      4'd3:    return 5'h1D;
      4'd4:    return 5'h0E;
      4'd5:    return 5'h0F;
      4'd6:    return 5'h1F;
      4'd7:    return 5'h00;
      4'd8:    return 5'h10;
      4'd9:    return 5'h0A;
      4'd10:   return 5'h1A;
      default: return 5'h0B;
    endcase
  endfunction

  state_t      state_q;
  logic [2:0]  sync_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] per_q;
  logic [3:0]  oct_q;
  logic [3:0]  idx_q;
  logic [1:0]  dir_q;
  logic [8:0]  res_q;
  logic        to_q;
  logic [8:0]  code_q;
  logic        valid_q;
  logic        rise;
  logic [31:0] lb_cur;
  logic        commit;
`ifdef NOTE_DEBOUNCE_EN
  logic [8:0]  last_q;
`endif

  assign rise = sync_q[1] & ~sync_q[2];

  // The period counter runs in every state but IDLE so edges during decode start the next period.
  always_comb begin
    cnt_d  = cnt_q + 32'd1;
    lb_cur = lower_bound(idx_q);
    if (state_q == IDLE) cnt_d = rise ? 32'd1 : 32'd0;
    else if (rise)       cnt_d = 32'd1;
  end

`ifdef NOTE_DEBOUNCE_EN
  // Silence bypasses the repeat requirement: a timeout is already a sustained condition.
  assign commit = (to_q || (res_q == last_q)) && (res_q != code_q);
`else
  assign commit = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      sync_q  <= 3'b000;
      cnt_q   <= 32'd0;
      per_q   <= 32'd0;
      oct_q   <= 4'd4;
      idx_q   <= 4'd0;
      dir_q   <= DIR_NONE;
      res_q   <= REST;
      to_q    <= 1'b0;
      code_q  <= REST;
      valid_q <= 1'b0;
`ifdef NOTE_DEBOUNCE_EN
      last_q  <= REST;
`endif
    end else begin
      sync_q  <= {sync_q[1], sync_q[0], i_Note};
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (rise) state_q <= MEASURE;
        MEASURE: begin
          if (rise) begin
            if (cnt_q >= 32'd2) begin
              per_q   <= cnt_q;
              oct_q   <= 4'd4;
              dir_q   <= DIR_NONE;
              state_q <= NORMALIZE;
            end
          end else if (cnt_q >= TO_LIM) begin
            res_q   <= REST;
            to_q    <= 1'b1;
            state_q <= EMIT;
          end
        end
        NORMALIZE: begin
          // dir_q stops a period sitting in a truncation gap from bouncing between octaves.
          if (per_q < WIN_LO && dir_q != DIR_R) begin
            if (oct_q == 4'd9) begin
              res_q   <= REST;
              to_q    <= 1'b0;
              state_q <= EMIT;
            end else begin
              per_q <= per_q << 1;
              oct_q <= oct_q + 4'd1;
              dir_q <= DIR_L;
            end
          end else if (per_q > WIN_HI && dir_q != DIR_L) begin
            if (oct_q == 4'd0) begin
              res_q   <= REST;
              to_q    <= 1'b0;
              state_q <= EMIT;
            end else begin
              per_q <= per_q >> 1;
              oct_q <= oct_q - 4'd1;
              dir_q <= DIR_R;
            end
          end else begin
            idx_q   <= 4'd0;
            state_q <= MATCH;
          end
        end
        MATCH: begin
          if (per_q >= lb_cur || idx_q == 4'd11) begin
            res_q   <= {semi_code(idx_q), oct_q};
            to_q    <= 1'b0;
            state_q <= EMIT;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        EMIT: begin
          if (commit) begin
            code_q  <= res_q;
            valid_q <= 1'b1;
          end
`ifdef NOTE_DEBOUNCE_EN
          last_q <= res_q;
`endif
          state_q <= to_q ? IDLE : MEASURE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_NoteCode = code_q;
  assign o_Valid    = valid_q;
  assign o_Busy     = (state_q == NORMALIZE) || (state_q == MATCH);
  assign o_State    = state_q;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector at a 1 MHz scaled clock; expected codes hand-computed from the note table.
module tb_note_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       note;
  logic [8:0] code;
  logic       valid;
  logic       busy;
  logic [2:0] state;

  note_detector #(.CLK_FREQ(1000000), .TIMEOUT_CYCLES(8000)) dut (
    .i_clk(clk), .i_reset(rst), .i_Note(note),
    .o_NoteCode(code), .o_Valid(valid), .o_Busy(busy), .o_State(state)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         first_valid_cyc = -1;
  int         busy_cnt = 0;
  int         edge_cyc[$];
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(code);
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    edge_cyc.delete();
    first_valid_cyc = -1;
    busy_cnt = 0;
  endtask

  // Leaves the bench 1 time unit after a rising clock edge, where play() expects to start.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    note = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic play(input int per, input int n);
    for (int k = 0; k < n; k++) begin
      note = 1'b1;
      edge_cyc.push_back(cyc);
      repeat (per / 2) @(posedge clk);
      #1 note = 1'b0;
      repeat (per - per / 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic expect_tone(input logic [8:0] c, input int ndec);
`ifdef NOTE_DEBOUNCE_EN
    if (ndec >= 2) exp_q.push_back(c);
`else
    repeat (ndec) exp_q.push_back(c);
`endif
  endtask

  task automatic compare_run(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  int         pers[3]  = '{379, 536, 637};
  logic [8:0] codes[3] = '{9'h0E7, 9'h1A6, 9'h006};
  int         lat_idx;

  initial begin
    rst  = 1'b1;
    note = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_code",  32'(code),  32'h111);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_state", 32'(state), 32'h0);

    // 440 Hz: four edges close three periods
    do_reset();
    play(2272, 4);
    settle();
    expect_tone(9'h0A4, 3);
    compare_run("a4");
`ifdef NOTE_DEBOUNCE_EN
    lat_idx = 2;
`else
    lat_idx = 1;
`endif
    check("a4_valid_seen", 32'(first_valid_cyc >= 0), 32'h1);
    check("a4_latency_le24", 32'((first_valid_cyc - edge_cyc[lat_idx]) <= 24), 32'h1);
    check("a4_busy_seen", 32'(busy_cnt > 0), 32'h1);
    check("a4_busy_idle", 32'(busy), 32'h0);

    for (int t = 0; t < 3; t++) begin
      do_reset();
      play(pers[t], 4);
      settle();
      expect_tone(codes[t], 3);
      compare_run($sformatf("tone%0d", pers[t]));
    end

    // Silence after a short 440 Hz burst
    do_reset();
    play(2272, 3);
    repeat (8100) @(posedge clk);
    #1;
    expect_tone(9'h0A4, 2);
    exp_q.push_back(9'h111);
    compare_run("timeout");
    check("timeout_code", 32'(code), 32'h111);
    check("timeout_state", 32'(state), 32'h0);

    // 880 Hz then 988 Hz without a gap
    do_reset();
    play(1136, 3);
    play(1012, 3);
    settle();
    expect_tone(9'h0A5, 3);
    expect_tone(9'h0B5, 2);
    compare_run("switch");

    // Reset in the middle of a measurement
    do_reset();
    play(2272, 2);
    repeat (1000) @(posedge clk);
    expect_tone(9'h0A4, 1);
    compare_run("pre_rst");
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_code",  32'(code),  32'h111);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_busy",  32'(busy),  32'h0);
    check("midrst_state", 32'(state), 32'h0);
    @(negedge clk);
    check("midrst_valid_next", 32'(valid), 32'h0);
    @(posedge clk); #1;
    clear_logs();
    play(2272, 3);
    settle();
    expect_tone(9'h0A4, 2);
    compare_run("resume");

    // Sub-cycle pulse and one single-cycle pulse
    do_reset();
    repeat (100) @(posedge clk);
    #2 note = 1'b1;
    #2 note = 1'b0;
    @(posedge clk); #1 note = 1'b1;
    @(posedge clk); #1 note = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    check("glitch_valid_count", 32'(got_q.size()), 32'h0);
    check("glitch_code", 32'(code), 32'h111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, i_clk frequency in Hz.
REQ-002 Parameter TIMEOUT_CYCLES, default CLK_FREQ/16, count with no rising edge after which input is treated as silence.
REQ-003 i_clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_Note  input  1  asynchronous square-wave tone, same format as the tone generator output.
REQ-006 o_NoteCode  output  9  decoded note: bit8 sharp, [7:4] letter (A,B,C,D,E,F hex; 0 = G), [3:0] octave; 'h111 = rest.
REQ-007 o_Valid  output  1  one-cycle strobe when o_NoteCode is updated.
REQ-008 o_Busy  output  1  high while normalising/matching.

Function
REQ-009 i_Note SHALL pass a 2-flop synchroniser; rising edge detected on synchronised 0->1.
REQ-010 FSM states SHALL be IDLE, MEASURE, NORMALIZE, MATCH, EMIT.
REQ-011 IDLE: wait for first rising edge, clear period counter, go MEASURE.
REQ-012 MEASURE: 32-bit counter increments each cycle; next rising edge latches count as P and goes NORMALIZE, counter restarts at 1 (back-to-back measurement).
REQ-013 Counter reaching TIMEOUT_CYCLES SHALL produce code 'h111 via EMIT, then return to IDLE.
REQ-014 Octave-4 table: 12 semitone periods CLK_FREQ/f (C4 261.63 Hz .. B4 493.88 Hz), integer-truncated at elaboration; boundaries = arithmetic midpoints, outer bounds = midpoint to B3 and C5.
REQ-015 NORMALIZE: octave starts at 4; per cycle, P below lower bound -> P<<1, octave+1; above upper bound -> P>>1, octave-1; one shift per cycle.
REQ-016 Octave SHALL clamp to 0..9; a further shift needed at a clamp -> code 'h111.
REQ-017 MATCH: scan table one entry per cycle, select semitone whose boundary window contains P.
REQ-018 Semitone mapping: C 0C, C# 1C, D 0D, D# 1D, E 0E, F 0F, F# 1F, G 00, G# 10, A 0A, A# 1A, B 0B.
REQ-019 EMIT: o_NoteCode updates, o_Valid high exactly one cycle, return to MEASURE (or IDLE after timeout).
REQ-020 Latency, closing synchronised edge to o_Valid: at most 24 cycles.
REQ-021 Rising edge arriving during NORMALIZE/MATCH/EMIT SHALL be counted as the start of the next period (counter keeps running), not dropped.
REQ-022 o_Busy high in NORMALIZE and MATCH only.
REQ-023 P = 0 or 1 (glitch) SHALL be discarded, no o_Valid.

Reset
REQ-024 On i_reset: FSM IDLE, counter 0, synchroniser 0, o_NoteCode 'h111, o_Valid 0, o_Busy 0.
REQ-025 Reset mid-operation SHALL abort the current measurement; no o_Valid in the reset cycle or the cycle after.

Configuration
REQ-026 Macro NOTE_DEBOUNCE_EN defined: o_Valid only when two consecutive decodes are identical and differ from current o_NoteCode; otherwise o_NoteCode holds.
REQ-027 Macro undefined: every completed decode (including rest) drives o_NoteCode and o_Valid.

Verification
REQ-028 440 Hz (113636-cycle period) after reset -> o_NoteCode 'h0A4, o_Valid within 24 cycles of second edge.
REQ-029 2637 Hz (18961 cycles) -> 'h0E7; 1864.66 Hz -> 'h1A6; 1567.98 Hz -> 'h006.
REQ-030 Input held low > TIMEOUT_CYCLES (3125000) -> 'h111 with one o_Valid pulse.
REQ-031 Switch 880 Hz -> 988 Hz mid-stream -> 'h0A5 then 'h0B5; debounce build: 'h0B5 only after second 988 Hz period.
REQ-032 i_reset asserted mid-MEASURE -> outputs at reset values next cycle, no stray o_Valid, correct decode resumes after two edges.
REQ-033 Single-cycle glitch pulses on i_Note -> no o_Valid, o_NoteCode unchanged.
